// File: rtl/trace_packer.sv
// trace_packer: packs kept trace records into a FIFO and streams each as two 64-bit beats
// Ports: clk, rst (async, active-high); en/in_valid/in_pc/in_instr/in_drop trace input;
//        out_tvalid/out_tready/out_tdata/out_tlast stream; overflow/overflow_count loss status;
//        fifo_level occupancy.
// Macro TRACE_PACKER_SKIP_COUNT_EN: beat1[31:0] carries the skipped-entry count (else 0).
module trace_packer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PACKET_ITEMS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [63:0]                   in_pc,
  input  logic [31:0]                   in_instr,
  input  logic                          in_drop,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [63:0]                   out_tdata,
  output logic                          out_tlast,
  output logic                          overflow,
  output logic [15:0]                   overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PACKET_ITEMS + 1);
`ifdef TRACE_PACKER_SKIP_COUNT_EN
  localparam int RW = 128;
`else
  localparam int RW = 96;
`endif
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rec_cnt;
  logic [RW-1:0] head, nxt, wdata;
  logic [31:0] head_skip;
  logic kept, full, push, lost, pop;
  assign kept = en && in_valid && !in_drop;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign push = kept && !full;
  assign lost = kept && full;
  assign pop  = state == BEAT1 && out_tready;
  assign head = mem[rd_ptr];
  assign nxt  = mem[rd_ptr + AW'(1)];
`ifdef TRACE_PACKER_SKIP_COUNT_EN
  logic [31:0] skip_cnt;
  assign wdata     = {in_pc, in_instr, skip_cnt};
  assign head_skip = head[31:0];
  // A lost kept entry counts as skipped, so the next record shows the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_cnt <= '0;
    else if (en && in_valid && (in_drop || full))
      skip_cnt <= skip_cnt == 32'hFFFF_FFFF ? skip_cnt : skip_cnt + 32'd1;
    else if (push) skip_cnt <= '0;
  end
`else
  assign wdata     = {in_pc, in_instr};
  assign head_skip = 32'd0;
`endif
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      overflow       <= 1'b0;
      overflow_count <= '0;
      rec_cnt        <= '0;
      state          <= IDLE;
      out_tvalid     <= 1'b0;
      out_tdata      <= '0;
      out_tlast      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (lost) begin
        overflow       <= 1'b1;
        overflow_count <= overflow_count == 16'hFFFF ? overflow_count : overflow_count + 16'd1;
      end
      case (state)
        IDLE: if (fifo_level != '0) begin
          state      <= BEAT0;
          out_tvalid <= 1'b1;
          out_tdata  <= head[RW-1 -: 64];
          out_tlast  <= 1'b0;
        end
        BEAT0: if (out_tready) begin
          state     <= BEAT1;
          out_tdata <= {head[RW-65 -: 32], head_skip};
          out_tlast <= rec_cnt == CW'(PACKET_ITEMS - 1);
        end
        BEAT1: if (out_tready) begin
          rec_cnt   <= out_tlast ? '0 : rec_cnt + CW'(1);
          out_tlast <= 1'b0;
          // Chain straight into the next record when one is already stored behind the head.
          if (fifo_level > LW'(1)) begin
            state     <= BEAT0;
            out_tdata <= nxt[RW-1 -: 64];
          end else begin
            state      <= IDLE;
            out_tvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: directed self-checking bench for trace_packer
module tb_trace_packer;
`ifdef TRACE_PACKER_SKIP_COUNT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, in_valid = 0, in_drop = 0, out_tready = 0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic out_tvalid, out_tlast, overflow;
  logic [63:0] out_tdata;
  logic [15:0] overflow_count;
  logic [4:0] fifo_level;
  int tests = 0, fails = 0;
  logic [63:0] beats[$];
  logic lasts[$];
  always #5 clk = ~clk;
  trace_packer dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_drop(in_drop), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .overflow(overflow), .overflow_count(overflow_count), .fifo_level(fifo_level)
  );
  always @(negedge clk) begin
    if (!rst && out_tvalid && out_tready) begin
      beats.push_back(out_tdata);
      lasts.push_back(out_tlast);
    end
  end
  task automatic cyc(input logic v, input logic d, input logic [63:0] pc, input logic [31:0] ins);
    @(posedge clk); #1;
    in_valid = v; in_drop = d; in_pc = pc; in_instr = ins;
  endtask
  task automatic idle(input int n);
    cyc(0, 0, 0, 0);
    repeat (n) @(posedge clk);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    beats.delete(); lasts.delete();
  endtask
  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({out_tvalid, out_tlast, out_tdata, overflow, overflow_count, fifo_level} !== '0) begin
      fails++;
      $display("FAIL reset_state: got tvalid=%b tlast=%b tdata=%h ovf=%b cnt=%0d lvl=%0d, want all 0",
               out_tvalid, out_tlast, out_tdata, overflow, overflow_count, fifo_level);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic test_skip_count();
    logic [63:0] exp1;
    exp1 = {32'h0000_006F, SKIP ? 32'd3 : 32'd0};
    en = 1; out_tready = 1;
    repeat (3) cyc(1, 1, 64'h1234, 32'h1);
    cyc(1, 0, 64'h8000_0010, 32'h0000_006F);
    idle(10);
    tests++;
    if (beats.size() != 2) begin
      fails++; $display("FAIL skip_beats: got %0d beats, want 2", beats.size());
    end else begin
      tests++;
      if (beats[0] !== 64'h8000_0010) begin
        fails++; $display("FAIL skip_beat0: got %h, want %h", beats[0], 64'h8000_0010);
      end
      tests++;
      if (beats[1] !== exp1) begin
        fails++; $display("FAIL skip_beat1: got %h, want %h", beats[1], exp1);
      end
    end
  endtask
  task automatic test_packet();
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 64'(32'h10 + i), 32'h20 + 32'(i));
    idle(40);
    tests++;
    if (beats.size() != 20) begin
      fails++; $display("FAIL packet_count: got %0d beats, want 20", beats.size());
    end
    for (int i = 0; i < 20 && i < beats.size(); i++) begin
      e = (i % 2 == 0) ? 64'(32'h10 + i / 2) : {32'h20 + 32'(i / 2), 32'd0};
      tests++;
      if (beats[i] !== e || lasts[i] !== (i == 15)) begin
        fails++;
        $display("FAIL packet_beat%0d: got data=%h last=%b, want data=%h last=%b", i, beats[i], lasts[i], e, i == 15);
      end
    end
  endtask
  task automatic test_overflow();
    logic [63:0] e;
    do_reset();
    out_tready = 0;
    for (int i = 0; i < 18; i++) cyc(1, 0, 64'(32'h1000 + i), 32'h30 + 32'(i));
    cyc(0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || overflow_count !== 16'd2) begin
      fails++;
      $display("FAIL overflow_state: got lvl=%0d ovf=%b cnt=%0d, want lvl=16 ovf=1 cnt=2", fifo_level, overflow, overflow_count);
    end
    @(posedge clk); #1;
    out_tready = 1;
    repeat (40) @(posedge clk);
    tests++;
    if (beats.size() != 32) begin
      fails++; $display("FAIL overflow_drain: got %0d beats, want 32", beats.size());
    end else begin
      tests++;
      if (beats[0] !== 64'h1000 || beats[30] !== 64'h100F || beats[31] !== {32'h3F, 32'd0} || lasts[15] !== 1'b1 || lasts[31] !== 1'b1) begin
        fails++;
        $display("FAIL overflow_order: got b0=%h b30=%h b31=%h l15=%b l31=%b, want 1000 100f 0000003f00000000 1 1",
                 beats[0], beats[30], beats[31], lasts[15], lasts[31]);
      end
    end
    tests++;
    if (overflow !== 1'b1 || overflow_count !== 16'd2) begin
      fails++; $display("FAIL overflow_sticky: got ovf=%b cnt=%0d, want 1 2", overflow, overflow_count);
    end
    beats.delete(); lasts.delete();
    cyc(1, 0, 64'hABC, 32'h13);
    idle(10);
    e = {32'h13, SKIP ? 32'd2 : 32'd0};
    tests++;
    if (beats.size() != 2 || beats[1] !== e || lasts[1] !== 1'b0) begin
      fails++; $display("FAIL overflow_skip: got n=%0d beat1=%h, want n=2 beat1=%h", beats.size(), beats.size() > 1 ? beats[1] : 64'hx, e);
    end
  endtask
  task automatic test_toggle();
    logic pv, pr, pl;
    logic [63:0] pd, e;
    do_reset();
    out_tready = 0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 64'(32'h200 + i), 32'h40 + 32'(i));
    cyc(0, 0, 0, 0);
    pv = 0; pr = 0; pl = 0; pd = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      out_tready = ~out_tready;
      @(negedge clk);
      if (pv && !pr) begin
        tests++;
        if (!(out_tvalid === 1'b1 && out_tdata === pd && out_tlast === pl)) begin
          fails++;
          $display("FAIL toggle_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b", out_tvalid, out_tdata, out_tlast, pd, pl);
        end
      end
      pv = out_tvalid; pr = out_tready; pd = out_tdata; pl = out_tlast;
    end
    @(posedge clk); #1;
    out_tready = 1;
    repeat (5) @(posedge clk);
    tests++;
    if (beats.size() != 8) begin
      fails++; $display("FAIL toggle_count: got %0d beats, want 8", beats.size());
    end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      e = (i % 2 == 0) ? 64'(32'h200 + i / 2) : {32'h40 + 32'(i / 2), 32'd0};
      tests++;
      if (beats[i] !== e || lasts[i] !== 1'b0) begin
        fails++; $display("FAIL toggle_beat%0d: got %h last=%b, want %h last=0", i, beats[i], lasts[i], e);
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    out_tready = 0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 64'(32'h300 + i), 32'h50 + 32'(i));
    cyc(0, 0, 0, 0);
    @(posedge clk); #1;
    out_tready = 1;
    @(posedge clk); #1;
    out_tready = 0;
    @(negedge clk);
    tests++;
    if (out_tvalid !== 1'b1 || out_tdata !== {32'h50, 32'd0} || fifo_level !== 5'd4) begin
      fails++; $display("FAIL midreset_pre: got v=%b d=%h lvl=%0d, want v=1 d=0000005000000000 lvl=4", out_tvalid, out_tdata, fifo_level);
    end
    rst = 1;
    #1;
    tests++;
    if ({out_tvalid, out_tlast, out_tdata, overflow, overflow_count, fifo_level} !== '0) begin
      fails++; $display("FAIL midreset_zero: got v=%b d=%h lvl=%0d, want all 0", out_tvalid, out_tdata, fifo_level);
    end
    @(posedge clk); #1;
    rst = 0; out_tready = 1;
    beats.delete(); lasts.delete();
    cyc(1, 0, 64'h100, 32'h60);
    idle(10);
    tests++;
    if (beats.size() != 2 || beats[0] !== 64'h100 || lasts[1] !== 1'b0) begin
      fails++; $display("FAIL midreset_first: got n=%0d beat0=%h, want n=2 beat0=100", beats.size(), beats.size() > 0 ? beats[0] : 64'hx);
    end
  endtask
  task automatic test_en();
    beats.delete(); lasts.delete();
    en = 0;
    cyc(1, 0, 64'h700, 32'h70);
    cyc(1, 0, 64'h701, 32'h71);
    cyc(1, 1, 64'h702, 32'h72);
    cyc(1, 1, 64'h703, 32'h73);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (fifo_level !== 5'd0 || beats.size() != 0) begin
      fails++; $display("FAIL en_low: got lvl=%0d beats=%0d, want 0 0", fifo_level, beats.size());
    end
    en = 1;
    cyc(1, 0, 64'h800, 32'h80);
    idle(10);
    tests++;
    if (beats.size() != 2 || beats[1] !== {32'h80, 32'd0}) begin
      fails++; $display("FAIL en_skiphold: got n=%0d beat1=%h, want n=2 beat1=0000008000000000", beats.size(), beats.size() > 1 ? beats[1] : 64'hx);
    end
  endtask
  initial begin
    test_reset();
    test_skip_count();
    test_packet();
    test_overflow();
    test_toggle();
    test_reset_mid();
    test_en();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
